// File: rtl/armcpu_pkg.sv
// Shared ARM core definitions: register addressing and register-file helpers.
package armcpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int NUM_GPR    = 15;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_PC = 4'd15;

    // One-hot decode of a register address onto the 15 general-purpose registers.
    // R15 decodes to all zeros: it is never stored in the array or the scoreboard.
    function automatic logic [NUM_GPR-1:0] gpr_onehot(input reg_addr_t addr);
        logic [NUM_GPR-1:0] oh;
        oh = {NUM_GPR{1'b0}};
        for (int i = 0; i < NUM_GPR; i++) begin
            if (addr == reg_addr_t'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard for R0-R14 with three hazard lookup ports.
module reg_scoreboard
    import armcpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      iss_en,
    input  reg_addr_t iss_addr,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_addr_t lk_addr_a,
    input  reg_addr_t lk_addr_b,
    input  reg_addr_t lk_addr_c,
    output logic      busy_a,
    output logic      busy_b,
    output logic      busy_c
);

    logic [NUM_GPR-1:0] pending_q;
    logic [NUM_GPR-1:0] pending_d;
    logic [NUM_GPR-1:0] set_oh_s;
    logic [NUM_GPR-1:0] clr_oh_s;

    // Busy when the register is pending and no same-cycle writeback resolves it.
    function automatic logic busy_of(input logic [NUM_GPR-1:0] pend,
                                     input reg_addr_t          addr,
                                     input logic               w_en,
                                     input reg_addr_t          w_addr);
        logic hit;
        hit = |(pend & gpr_onehot(addr));
        if (w_en && (w_addr == addr)) begin
            return 1'b0;
        end else begin
            return hit;
        end
    endfunction

    // Decode set/clear masks; iss_addr of 15 decodes to nothing and is ignored.
    always_comb begin
        set_oh_s = {NUM_GPR{1'b0}};
        clr_oh_s = {NUM_GPR{1'b0}};
        if (iss_en) begin
            set_oh_s = gpr_onehot(iss_addr);
        end else begin
            set_oh_s = {NUM_GPR{1'b0}};
        end
        if (wr_en) begin
            clr_oh_s = gpr_onehot(wr_addr);
        end else begin
            clr_oh_s = {NUM_GPR{1'b0}};
        end
    end

    // Next pending state: clear applied first so a same-cycle set wins.
    always_comb begin
        pending_d = (pending_q & ~clr_oh_s) | set_oh_s;
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= {NUM_GPR{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    // Hazard lookups for the three read ports.
    always_comb begin
        busy_a = busy_of(pending_q, lk_addr_a, wr_en, wr_addr);
        busy_b = busy_of(pending_q, lk_addr_b, wr_en, wr_addr);
        busy_c = busy_of(pending_q, lk_addr_c, wr_en, wr_addr);
    end

endmodule

// File: rtl/reg_file_sb.sv
// ARM integer register file: R0-R14 array, dedicated PC, three read ports with
// write-through forwarding, and a pending-write scoreboard for RAW hazards.
module reg_file_sb
    import armcpu_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_0000,
    parameter int                 PC_OFFSET = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_addr_t        rd_addr_a,
    input  reg_addr_t        rd_addr_b,
    input  reg_addr_t        rd_addr_c,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             rd_busy_a,
    output logic             rd_busy_b,
    output logic             rd_busy_c,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_en,
    input  logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc,
    input  logic             iss_en,
    input  reg_addr_t        iss_addr
);

    logic [NUM_GPR-1:0][WIDTH-1:0] regs_q;
    logic [NUM_GPR-1:0][WIDTH-1:0] regs_d;
    logic [WIDTH-1:0]              pc_q;
    logic [WIDTH-1:0]              pc_d;
    logic [WIDTH-1:0]              pc_read_s;
    logic                          wr_pc_s;

    // Read one port: R15 sees the offset PC (no forwarding), others forward
    // a same-cycle writeback ahead of the stored value.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [NUM_GPR-1:0][WIDTH-1:0] regs,
        input logic [WIDTH-1:0]              pc_rd,
        input reg_addr_t                     addr,
        input logic                          w_en,
        input reg_addr_t                     w_addr,
        input logic [WIDTH-1:0]              w_data
    );
        logic [WIDTH-1:0] val;
        val = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_GPR; i++) begin
            if (addr == reg_addr_t'(i)) begin
                val = regs[i];
            end else begin
                val = val;
            end
        end
        if (addr == REG_PC) begin
            return pc_rd;
        end else if (w_en && (w_addr == addr)) begin
            return w_data;
        end else begin
            return val;
        end
    endfunction

    // Architectural PC as seen by instructions, carry out discarded.
    always_comb begin
        pc_read_s = pc_q + WIDTH'(PC_OFFSET);
    end

    // Next-state for R0-R14: only the addressed register takes wr_data.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (wr_en && (wr_addr == reg_addr_t'(i))) begin
                regs_d[i] = wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Next PC: writeback to R15 beats the sequential update, else hold.
    always_comb begin
        wr_pc_s = wr_en && (wr_addr == REG_PC);
        pc_d    = pc_q;
        if (wr_pc_s) begin
            pc_d = wr_data;
        end else if (pc_en) begin
            pc_d = pc_next;
        end else begin
            pc_d = pc_q;
        end
    end

    // Register array and PC state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= {(NUM_GPR*WIDTH){1'b0}};
            pc_q   <= RESET_PC;
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data_a = read_port(regs_q, pc_read_s, rd_addr_a, wr_en, wr_addr, wr_data);
        rd_data_b = read_port(regs_q, pc_read_s, rd_addr_b, wr_en, wr_addr, wr_data);
        rd_data_c = read_port(regs_q, pc_read_s, rd_addr_c, wr_en, wr_addr, wr_data);
        pc        = pc_q;
    end

    reg_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .lk_addr_a (rd_addr_a),
        .lk_addr_b (rd_addr_b),
        .lk_addr_c (rd_addr_c),
        .busy_a    (rd_busy_a),
        .busy_b    (rd_busy_b),
        .busy_c    (rd_busy_c)
    );

endmodule
